// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    function automatic logic is_div(muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(muldiv_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic rs0_signed(muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic rs1_signed(muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_resbuf.sv
// Result FIFO of {tag, data}; head is registered storage, flush empties it.
module muldiv_resbuf
    import muldiv_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [TAG_W-1:0]             push_tag,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         head_valid,
    output logic [TAG_W-1:0]             head_tag,
    output logic [DATA_W-1:0]            head_data
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = TAG_W + DATA_W;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty, full, push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = {push_tag, push_data};
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count      = count_q;
    assign head_valid = ~empty;
    assign head_tag   = mem_q[rd_ptr_q][ENT_W-1:DATA_W];
    assign head_data  = mem_q[rd_ptr_q][DATA_W-1:0];

endmodule

// File: rtl/muldiv_iter_unit.sv
// Bit-serial RISC-V M-extension unit with a tagged result FIFO.
// Define MULDIV_EARLY_OUT_EN to let trivial operations bypass the iteration loop.
module muldiv_iter_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int RESBUF_DEPTH = 2,
    parameter int TAG_W        = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_pipeline,
    input  logic              mul_initial,
    input  logic [2:0]        mul_para,
    input  logic [TAG_W-1:0]  mul_tag,
    input  logic [XLEN-1:0]   mul_rs0,
    input  logic [XLEN-1:0]   mul_rs1,
    output logic              mul_ready,
    output logic              mul_finished,
    output logic [XLEN-1:0]   mul_data,
    output logic [TAG_W-1:0]  mul_tag_out,
    input  logic              mul_ack
);

    localparam int CNT_W  = $clog2(XLEN + 1);
    localparam int FCNT_W = $clog2(RESBUF_DEPTH + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*XLEN-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]    b_mag_q, b_mag_d;
    logic [XLEN-1:0]    rs0_q, rs0_d;
    muldiv_op_e         op_q, op_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic               ovf_q, ovf_d;

    muldiv_op_e         op_in;
    logic               a_neg, b_neg, div_zero_in, ovf_in;
    logic [XLEN-1:0]    a_mag, b_mag;
    logic               accept, push;
    logic [FCNT_W-1:0]  fifo_count;
    logic [XLEN:0]      mul_sum, rem_sh, rem_diff;
    logic [XLEN-1:0]    rem_next;
    logic               q_bit;
    logic [2*XLEN-1:0]  prod;
    logic [XLEN-1:0]    result;

    assign op_in       = muldiv_op_e'(mul_para);
    assign a_neg       = rs0_signed(op_in) & mul_rs0[XLEN-1];
    assign b_neg       = rs1_signed(op_in) & mul_rs1[XLEN-1];
    assign a_mag       = a_neg ? -mul_rs0 : mul_rs0;
    assign b_mag       = b_neg ? -mul_rs1 : mul_rs1;
    assign div_zero_in = is_div(op_in) & (mul_rs1 == '0);
    assign ovf_in      = ((op_in == OP_DIV) || (op_in == OP_REM)) &
                         (mul_rs0 == MOST_NEG) & (&mul_rs1);

    assign mul_ready = (state_q == ST_IDLE) & (fifo_count < FCNT_W'(RESBUF_DEPTH));
    assign accept    = mul_initial & mul_ready & ~clear_pipeline;

`ifdef MULDIV_EARLY_OUT_EN
    logic trivial_in;
    assign trivial_in = is_div(op_in) ? (div_zero_in | ovf_in | (a_mag < b_mag))
                                      : ((mul_rs0 == '0) | (mul_rs1 == '0));
`endif

    // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_mag_q : '0)};
    // Divide: acc = {partial remainder, remaining dividend / growing quotient}.
    assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign rem_diff = rem_sh - {1'b0, b_mag_q};
    assign q_bit    = ~rem_diff[XLEN];
    assign rem_next = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_mag_d   = b_mag_q;
        rs0_d     = rs0_q;
        op_d      = op_q;
        tag_d     = tag_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        push      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d      = op_in;
                    tag_d     = mul_tag;
                    rs0_d     = mul_rs0;
                    b_mag_d   = b_mag;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dz_d      = div_zero_in;
                    ovf_d     = ovf_in;
                    acc_d     = {{XLEN{1'b0}}, a_mag};
                    cnt_d     = CNT_W'(XLEN);
                    state_d   = ST_CALC;
`ifdef MULDIV_EARLY_OUT_EN
                    if (trivial_in) begin
                        // Leaves acc holding the final magnitudes: product 0, or q=0/r=|rs0|.
                        acc_d   = is_div(op_in) ? {a_mag, {XLEN{1'b0}}} : '0;
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                acc_d = is_div(op_q) ? {rem_next, acc_q[XLEN-2:0], q_bit}
                                     : {mul_sum, acc_q[XLEN-1:1]};
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                push    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear_pipeline) begin
            state_d = ST_IDLE;
            push    = 1'b0;
        end
    end

    assign prod = neg_res_q ? -acc_q : acc_q;

    always_comb begin
        result = '0;
        if (is_div(op_q)) begin
            if (dz_q) begin
                result = is_rem(op_q) ? rs0_q : '1;
            end else if (ovf_q) begin
                result = is_rem(op_q) ? '0 : rs0_q;
            end else if (is_rem(op_q)) begin
                result = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
            end else begin
                result = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
            end
        end else begin
            result = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_mag_q   <= '0;
            rs0_q     <= '0;
            op_q      <= OP_MUL;
            tag_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_mag_q   <= b_mag_d;
            rs0_q     <= rs0_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
        end
    end

    muldiv_resbuf #(
        .DEPTH  (RESBUF_DEPTH),
        .TAG_W  (TAG_W),
        .DATA_W (XLEN)
    ) u_resbuf (
        .clk        (clk),
        .rst        (rst),
        .flush      (clear_pipeline),
        .push       (push),
        .push_tag   (tag_q),
        .push_data  (result),
        .pop        (mul_ack),
        .count      (fifo_count),
        .head_valid (mul_finished),
        .head_tag   (mul_tag_out),
        .head_data  (mul_data)
    );

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Scoreboard bench for muldiv_iter_unit: directed M-extension vectors, FIFO backpressure and flush.
// Handshake: a result is consumed on a clock edge where mul_finished and mul_ack are both high.
module tb_muldiv_iter_unit;
    import muldiv_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int TAG_W = 5;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [XLEN-1:0]  res;
        bit               triv;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear_pipeline;
    logic             mul_initial;
    logic [2:0]       mul_para;
    logic [TAG_W-1:0] mul_tag;
    logic [XLEN-1:0]  mul_rs0;
    logic [XLEN-1:0]  mul_rs1;
    logic             mul_ready;
    logic             mul_finished;
    logic [XLEN-1:0]  mul_data;
    logic [TAG_W-1:0] mul_tag_out;
    logic             mul_ack;

    int checks = 0;
    int errors = 0;
    logic [TAG_W+XLEN-1:0] exp_q[$];
    bit   ack_en     = 1'b0;
    int   ack_credit = 0;
    vec_t vecs[20];

    muldiv_iter_unit #(
        .XLEN         (XLEN),
        .RESBUF_DEPTH (DEPTH),
        .TAG_W        (TAG_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clear_pipeline (clear_pipeline),
        .mul_initial    (mul_initial),
        .mul_para       (mul_para),
        .mul_tag        (mul_tag),
        .mul_rs0        (mul_rs0),
        .mul_rs1        (mul_rs1),
        .mul_ready      (mul_ready),
        .mul_finished   (mul_finished),
        .mul_data       (mul_data),
        .mul_tag_out    (mul_tag_out),
        .mul_ack        (mul_ack)
    );

    // ---------------- clock ----------------
    initial begin
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [2:0] op, input logic [TAG_W-1:0] tag,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input bit expect_it, input logic [XLEN-1:0] res);
        int n;
        n = 0;
        @(negedge clk);
        while (!mul_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", 64'(mul_ready), 64'd1);
        mul_para    = op;
        mul_tag     = tag;
        mul_rs0     = a;
        mul_rs1     = b;
        mul_initial = 1'b1;
        if (expect_it) exp_q.push_back({tag, res});
        @(posedge clk);
        #1;
        mul_initial = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        ack_en = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        ack_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_timed(input vec_t v);
        int lat;
        int exp_lat;
        exp_lat = (EARLY && v.triv) ? 1 : XLEN + 1;
        ack_en  = 1'b0;
        issue(v.op, v.tag, v.a, v.b, 1'b1, v.res);
        lat = 0;
        for (int i = 1; i <= XLEN + 8; i++) begin
            @(posedge clk);
            #1;
            if (mul_finished) begin
                lat = i;
                break;
            end
        end
        check("latency", 64'(lat), 64'(exp_lat));
        drain();
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [TAG_W+XLEN-1:0] exp_item;
        mul_ack = 1'b0;
        forever begin
            @(negedge clk);
            mul_ack = 1'b0;
            if (!rst && mul_finished && (ack_en || ack_credit > 0)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got tag %0d data 0x%0h, required no result",
                             mul_tag_out, mul_data);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("result_tag_data", 64'({mul_tag_out, mul_data}), 64'(exp_item));
                end
                mul_ack = 1'b1;
                if (ack_credit > 0) ack_credit--;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        vecs[0]  = '{3'd1, 5'd7,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0};
        vecs[1]  = '{3'd0, 5'd8,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, 1'b0};
        vecs[2]  = '{3'd4, 5'd9,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[3]  = '{3'd6, 5'd10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[4]  = '{3'd5, 5'd11, 32'd7,        32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{3'd7, 5'd12, 32'd7,        32'd0,        32'd7,        1'b1};
        vecs[6]  = '{3'd6, 5'd13, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0};
        vecs[7]  = '{3'd4, 5'd14, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{3'd2, 5'd15, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0};
        vecs[9]  = '{3'd3, 5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        vecs[10] = '{3'd5, 5'd17, 32'd100,      32'd7,        32'd14,       1'b0};
        vecs[11] = '{3'd7, 5'd18, 32'd100,      32'd7,        32'd2,        1'b0};
        vecs[12] = '{3'd6, 5'd19, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0};
        vecs[13] = '{3'd4, 5'd20, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
        vecs[14] = '{3'd4, 5'd21, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[15] = '{3'd6, 5'd22, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b1};
        vecs[16] = '{3'd0, 5'd23, 32'd0,        32'd5,        32'd0,        1'b1};
        vecs[17] = '{3'd5, 5'd24, 32'd3,        32'd10,       32'd0,        1'b1};
        vecs[18] = '{3'd7, 5'd25, 32'd3,        32'd10,       32'd3,        1'b1};
        vecs[19] = '{3'd1, 5'd26, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};

        rst            = 1'b1;
        clear_pipeline = 1'b0;
        mul_initial    = 1'b0;
        mul_para       = '0;
        mul_tag        = '0;
        mul_rs0        = '0;
        mul_rs1        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready",    64'(mul_ready),    64'd1);
        check("reset_finished", 64'(mul_finished), 64'd0);
        check("reset_data",     64'(mul_data),     64'd0);
        check("reset_tag",      64'(mul_tag_out),  64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", 64'(mul_ready), 64'd1);

        foreach (vecs[i]) run_timed(vecs[i]);

        // Two queued MULHU results, third op held until one slot frees.
        ack_en = 1'b0;
        issue(3'd3, 5'd1, 32'h00010000, 32'h00010000, 1'b1, 32'd1);
        issue(3'd3, 5'd2, 32'h80000000, 32'd4,        1'b1, 32'd2);
        repeat (XLEN + 2) @(posedge clk);
        #1;
        check("full_ready",    64'(mul_ready),    64'd0);
        check("full_finished", 64'(mul_finished), 64'd1);
        check("full_head_tag", 64'(mul_tag_out),  64'd1);
        @(negedge clk);
        mul_para    = 3'd3;
        mul_tag     = 5'd3;
        mul_rs0     = 32'hC0000000;
        mul_rs1     = 32'd4;
        mul_initial = 1'b1;
        exp_q.push_back({5'd3, 32'd3});
        repeat (3) @(posedge clk);
        #1;
        check("held_ready", 64'(mul_ready), 64'd0);
        ack_credit = 1;
        @(posedge clk);
        #1;
        check("ready_after_ack", 64'(mul_ready), 64'd1);
        @(posedge clk);
        #1;
        mul_initial = 1'b0;
        check("busy_after_accept", 64'(mul_ready), 64'd0);
        drain();

        // Flush during a DIV with one result already queued.
        ack_en = 1'b0;
        issue(3'd5, 5'd4, 32'd100, 32'd7, 1'b0, 32'd0);
        begin
            int n;
            n = 0;
            while (!mul_finished && n < 60) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("queued_before_clear", 64'(mul_finished), 64'd1);
        end
        issue(3'd4, 5'd5, 32'hFFFFFF9C, 32'd7, 1'b0, 32'd0);
        repeat (9) @(posedge clk);
        #1;
        clear_pipeline = 1'b1;
        @(posedge clk);
        #1;
        clear_pipeline = 1'b0;
        check("clear_finished", 64'(mul_finished), 64'd0);
        check("clear_ready",    64'(mul_ready),    64'd1);
        repeat (XLEN + 8) @(posedge clk);
        #1;
        check("no_ghost_result", 64'(mul_finished), 64'd0);
        run_timed('{3'd7, 5'd30, 32'd100, 32'd7, 32'd2, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
